// File: rtl/spi_xfer_sequencer.sv
// Drives an SPI core's control port through one full-duplex word transfer: poll TRDY,
// write txdata, poll RRDY, read rxdata, then hand the received word back on a response port.
module spi_xfer_sequencer #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_LIMIT    = 1023
) (
  input  logic        clk_1x,
  input  logic        rst_1x,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_txdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rxdata,
  output logic        rsp_error,
  output logic        spi_rden,
  output logic        spi_wren,
  output logic [2:0]  spi_address,
  output logic [31:0] spi_writedata,
  input  logic [31:0] spi_readdata
);

  localparam logic [2:0]  StrobeLen = 3'(STROBE_CYCLES);
  localparam logic [15:0] PollMax   = 16'(POLL_LIMIT);

  localparam logic [2:0] AddrRxdata = 3'd0;
  localparam logic [2:0] AddrTxdata = 3'd1;
  localparam logic [2:0] AddrStatus = 3'd2;

  typedef enum logic [3:0] {
    StIdle,
    StTpoll,
    StTchk,
    StTxwr,
    StRpoll,
    StRchk,
    StRxrd,
    StRxcap,
    StResp
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] poll_cnt_q;
  logic [31:0] tx_q;

  always_ff @(posedge clk_1x or posedge rst_1x) begin
    if (rst_1x) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      poll_cnt_q    <= 16'd0;
      tx_q          <= 32'd0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rxdata    <= 32'd0;
      rsp_error     <= 1'b0;
      spi_rden      <= 1'b0;
      spi_wren      <= 1'b0;
      spi_address   <= 3'd0;
      spi_writedata <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            tx_q        <= req_txdata;
            req_ready   <= 1'b0;
            poll_cnt_q  <= 16'd0;
            spi_address <= AddrStatus;
            state_q     <= StTpoll;
          end else begin
            req_ready <= 1'b1;
          end
        end

        // Poll states spend one lead-in cycle with the status address set before strobing.
        StTpoll, StRpoll: begin
          if (!spi_rden) begin
            spi_rden <= 1'b1;
            cnt_q    <= 3'd1;
          end else if (cnt_q == StrobeLen) begin
            spi_rden   <= 1'b0;
            poll_cnt_q <= poll_cnt_q + 16'd1;
            state_q    <= (state_q == StTpoll) ? StTchk : StRchk;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        StTchk: begin
          if (spi_readdata[6]) begin
            spi_wren      <= 1'b1;
            spi_address   <= AddrTxdata;
            spi_writedata <= tx_q;
            cnt_q         <= 3'd1;
            state_q       <= StTxwr;
          end else if (poll_cnt_q == PollMax) begin
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            rsp_rxdata <= 32'd0;
            state_q    <= StResp;
          end else begin
            state_q <= StTpoll;
          end
        end

        // Write strobe, then one idle cycle before the receive poll begins.
        StTxwr: begin
          if (spi_wren) begin
            if (cnt_q == StrobeLen) begin
              spi_wren <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end else begin
            spi_address <= AddrStatus;
            poll_cnt_q  <= 16'd0;
            state_q     <= StRpoll;
          end
        end

        StRchk: begin
          if (spi_readdata[7]) begin
            spi_rden    <= 1'b1;
            spi_address <= AddrRxdata;
            cnt_q       <= 3'd1;
            state_q     <= StRxrd;
          end else if (poll_cnt_q == PollMax) begin
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            rsp_rxdata <= 32'd0;
            state_q    <= StResp;
          end else begin
            state_q <= StRpoll;
          end
        end

        StRxrd: begin
          if (cnt_q == StrobeLen) begin
            spi_rden <= 1'b0;
            state_q  <= StRxcap;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        StRxcap: begin
          rsp_rxdata <= spi_readdata;
          rsp_error  <= 1'b0;
          rsp_valid  <= 1'b1;
          state_q    <= StResp;
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: three parameterisations share one SPI core model,
// selected by sel; a negedge monitor records strobe activity of the selected instance.
module tb_spi_xfer_sequencer;

  logic        clk_1x = 1'b0;
  logic        rst_1x = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_txdata = 32'd0;
  logic        rsp_ready = 1'b1;
  logic [31:0] spi_readdata;
  int          sel = 0;

  always #5 clk_1x = ~clk_1x;

  logic        rv[3];
  logic        rr[3], vv[3], er[3], rd[3], wr[3];
  logic [31:0] rx[3], wd[3];
  logic [2:0]  ad[3];

  assign rv[0] = req_valid && (sel == 0);
  assign rv[1] = req_valid && (sel == 1);
  assign rv[2] = req_valid && (sel == 2);

  spi_xfer_sequencer u_dflt (
    .clk_1x(clk_1x), .rst_1x(rst_1x), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_txdata(req_txdata), .rsp_valid(vv[0]), .rsp_ready(rsp_ready), .rsp_rxdata(rx[0]),
    .rsp_error(er[0]), .spi_rden(rd[0]), .spi_wren(wr[0]), .spi_address(ad[0]),
    .spi_writedata(wd[0]), .spi_readdata(spi_readdata)
  );

  spi_xfer_sequencer #(.STROBE_CYCLES(2), .POLL_LIMIT(3)) u_tmo (
    .clk_1x(clk_1x), .rst_1x(rst_1x), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_txdata(req_txdata), .rsp_valid(vv[1]), .rsp_ready(rsp_ready), .rsp_rxdata(rx[1]),
    .rsp_error(er[1]), .spi_rden(rd[1]), .spi_wren(wr[1]), .spi_address(ad[1]),
    .spi_writedata(wd[1]), .spi_readdata(spi_readdata)
  );

  spi_xfer_sequencer #(.STROBE_CYCLES(1), .POLL_LIMIT(1023)) u_s1 (
    .clk_1x(clk_1x), .rst_1x(rst_1x), .req_valid(rv[2]), .req_ready(rr[2]),
    .req_txdata(req_txdata), .rsp_valid(vv[2]), .rsp_ready(rsp_ready), .rsp_rxdata(rx[2]),
    .rsp_error(er[2]), .spi_rden(rd[2]), .spi_wren(wr[2]), .spi_address(ad[2]),
    .spi_writedata(wd[2]), .spi_readdata(spi_readdata)
  );

  logic        m_rr, m_vv, m_er, m_rd, m_wr;
  logic [31:0] m_rx, m_wd;
  logic [2:0]  m_ad;
  always_comb begin
    m_rr = rr[sel]; m_vv = vv[sel]; m_er = er[sel]; m_rd = rd[sel]; m_wr = wr[sel];
    m_rx = rx[sel]; m_wd = wd[sel]; m_ad = ad[sel];
  end

  // SPI core model: status reads step through stat_seq, sticking at the last entry.
  logic [31:0] stat_seq[16];
  int          stat_n = 1;
  logic [31:0] rx_word = 32'd0;
  int          n_stat, n_rd0, n_wr, stat_before_wr;
  int          stat_idx;
  always_comb begin
    stat_idx = (n_stat == 0) ? 0 : n_stat - 1;
    if (stat_idx >= stat_n) stat_idx = stat_n - 1;
    spi_readdata = 32'd0;
    if (m_ad == 3'd2) spi_readdata = stat_seq[stat_idx];
    else if (m_ad == 3'd0) spi_readdata = rx_word;
  end

  logic        mon_clr = 1'b0;
  int          mon_s = 2;
  logic        rd_p, wr_p;
  int          run, width_err, overlap, gap_err, stab_err;
  logic [2:0]  a_hold, wr_addr;
  logic [31:0] d_hold, wr_data;

  always @(negedge clk_1x) begin
    if (mon_clr) begin
      rd_p <= 1'b0; wr_p <= 1'b0; run <= 0; width_err <= 0; overlap <= 0; gap_err <= 0;
      stab_err <= 0; n_stat <= 0; n_rd0 <= 0; n_wr <= 0; stat_before_wr <= 0;
      wr_addr <= 3'd0; wr_data <= 32'd0; a_hold <= 3'd0; d_hold <= 32'd0;
    end else begin
      rd_p <= m_rd;
      wr_p <= m_wr;
      if (m_rd && m_wr) overlap <= overlap + 1;
      if ((rd_p && !m_rd) || (wr_p && !m_wr)) begin
        if (run != mon_s) width_err <= width_err + 1;
      end
      if (m_rd && !rd_p) begin
        if (wr_p) gap_err <= gap_err + 1;
        if (m_ad == 3'd2) n_stat <= n_stat + 1;
        if (m_ad == 3'd0) n_rd0 <= n_rd0 + 1;
        run <= 1; a_hold <= m_ad;
      end else if (m_wr && !wr_p) begin
        if (rd_p) gap_err <= gap_err + 1;
        if (n_wr == 0) stat_before_wr <= n_stat;
        n_wr <= n_wr + 1; wr_addr <= m_ad; wr_data <= m_wd;
        run <= 1; a_hold <= m_ad; d_hold <= m_wd;
      end else if (m_rd || m_wr) begin
        run <= run + 1;
        if (m_ad != a_hold) stab_err <= stab_err + 1;
        if (m_wr && (m_wd != d_hold)) stab_err <= stab_err + 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    repeat (2) @(negedge clk_1x);
    mon_clr = 1'b0;
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic start_req(input logic [31:0] w);
    logic got;
    got = 1'b0;
    req_txdata = w;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_rr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_1x);
    end
    chk("req_accept", 32'(got), 32'd1);
    @(posedge clk_1x);
    #1 req_valid = 1'b0;
  endtask

  // Counts posedges after acceptance until rsp_valid is seen; ends on that negedge.
  task automatic wait_rsp(output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_1x);
      if (m_vv) begin
        got = 1'b1;
        break;
      end
      @(posedge clk_1x);
      lat++;
    end
    chk("rsp_arrives", 32'(got), 32'd1);
  endtask

  int          lat;
  int          bad;
  int          seen;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 16; i++) stat_seq[i] = 32'h0C0;
    mon_clr = 1'b1;
    repeat (3) @(negedge clk_1x);
    chk("rst_req_ready", 32'(m_rr), 32'd0);
    chk("rst_rsp_valid", 32'(m_vv), 32'd0);
    chk("rst_rsp_rxdata", m_rx, 32'd0);
    chk("rst_rsp_error", 32'(m_er), 32'd0);
    chk("rst_strobes", {30'd0, m_rd, m_wr}, 32'd0);
    chk("rst_address", 32'(m_ad), 32'd0);
    chk("rst_writedata", m_wd, 32'd0);
    rst_1x = 1'b0;
    mon_clr = 1'b0;
    @(negedge clk_1x);
    chk("req_ready_after_rst", 32'(m_rr), 32'd1);

    // Basic transfer
    stat_n = 1; stat_seq[0] = 32'h0C0; rx_word = 32'h5A;
    start_req(32'hA5);
    wait_rsp(lat);
    chk("basic_latency", 32'(lat), 32'd14);
    chk("basic_rxdata", m_rx, 32'h5A);
    chk("basic_error", 32'(m_er), 32'd0);
    @(negedge clk_1x);
    chk("basic_rsp_same_cycle_accept", 32'(m_vv), 32'd0);
    chk("basic_req_ready_back", 32'(m_rr), 32'd1);
    chk("basic_n_wr", 32'(n_wr), 32'd1);
    chk("basic_wr_addr", 32'(wr_addr), 32'd1);
    chk("basic_wr_data", wr_data, 32'hA5);
    chk("basic_n_stat", 32'(n_stat), 32'd2);
    chk("basic_n_rd0", 32'(n_rd0), 32'd1);
    chk("basic_width_err", 32'(width_err), 32'd0);
    chk("basic_overlap", 32'(overlap), 32'd0);
    chk("basic_gap_err", 32'(gap_err), 32'd0);
    chk("basic_stab_err", 32'(stab_err), 32'd0);

    // TRDY delay: five busy status reads, then TRDY, then RRDY
    clear_mon();
    stat_n = 7;
    for (int i = 0; i < 5; i++) stat_seq[i] = 32'h000;
    stat_seq[5] = 32'h040; stat_seq[6] = 32'h080;
    rx_word = 32'h1234_5678;
    start_req(32'hCAFE_0001);
    wait_rsp(lat);
    chk("trdy_rxdata", m_rx, 32'h1234_5678);
    chk("trdy_error", 32'(m_er), 32'd0);
    @(negedge clk_1x);
    chk("trdy_tpoll_reads", 32'(stat_before_wr), 32'd6);
    chk("trdy_n_wr", 32'(n_wr), 32'd1);
    chk("trdy_rpoll_reads", 32'(n_stat - stat_before_wr), 32'd1);
    chk("trdy_wr_data", wr_data, 32'hCAFE_0001);
    chk("trdy_width_err", 32'(width_err), 32'd0);

    // Timeout on the POLL_LIMIT = 3 instance: RRDY never rises
    sel = 1;
    clear_mon();
    stat_n = 1; stat_seq[0] = 32'h040; rx_word = 32'hDEAD_BEEF;
    start_req(32'h77);
    wait_rsp(lat);
    chk("tmo_error", 32'(m_er), 32'd1);
    chk("tmo_rxdata", m_rx, 32'd0);
    @(negedge clk_1x);
    chk("tmo_rpoll_reads", 32'(n_stat - stat_before_wr), 32'd3);
    chk("tmo_n_rd0", 32'(n_rd0), 32'd0);
    chk("tmo_width_err", 32'(width_err), 32'd0);

    // Response backpressure
    sel = 0;
    clear_mon();
    stat_n = 1; stat_seq[0] = 32'h0C0; rx_word = 32'h0000_BEEF;
    rsp_ready = 1'b0;
    start_req(32'h11);
    wait_rsp(lat);
    held = m_rx;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!m_vv || (m_rx !== held) || m_rr) bad++;
      @(negedge clk_1x);
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_rxdata", held, 32'h0000_BEEF);
    rsp_ready = 1'b1;
    @(posedge clk_1x);
    #1;
    chk("bp_req_ready_after_hs", 32'(m_rr), 32'd1);
    chk("bp_valid_after_hs", 32'(m_vv), 32'd0);
    @(negedge clk_1x);

    // Reset during the first txdata write strobe cycle
    clear_mon();
    start_req(32'h99);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1x);
      if (m_wr) begin
        seen = 1;
        break;
      end
    end
    chk("mid_wren_reached", 32'(seen), 32'd1);
    rst_1x = 1'b1;
    #1;
    chk("mid_wren_dropped", 32'(m_wr), 32'd0);
    chk("mid_rden_low", 32'(m_rd), 32'd0);
    chk("mid_req_ready_low", 32'(m_rr), 32'd0);
    @(negedge clk_1x);
    rst_1x = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1x);
      if (m_vv || m_rd || m_wr) bad++;
    end
    chk("mid_no_response", 32'(bad), 32'd0);
    clear_mon();
    rx_word = 32'h5A;
    start_req(32'h33);
    wait_rsp(lat);
    chk("mid_after_latency", 32'(lat), 32'd14);
    chk("mid_after_error", 32'(m_er), 32'd0);
    chk("mid_after_rxdata", m_rx, 32'h5A);
    @(negedge clk_1x);
    chk("mid_after_wr_data", wr_data, 32'h33);

    // Single-cycle strobes
    sel = 2;
    mon_s = 1;
    clear_mon();
    start_req(32'hA5);
    wait_rsp(lat);
    chk("s1_latency", 32'(lat), 32'd10);
    chk("s1_rxdata", m_rx, 32'h5A);
    chk("s1_error", 32'(m_er), 32'd0);
    @(negedge clk_1x);
    chk("s1_overlap", 32'(overlap), 32'd0);
    chk("s1_width_err", 32'(width_err), 32'd0);
    chk("s1_gap_err", 32'(gap_err), 32'd0);
    chk("s1_wr_data", wr_data, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
